// File: rtl/serial_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// Run/Done handshake. Results and the divide-by-zero flag persist until the next division ends.
module serial_divider #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             no_borrow;
   logic [WIDTH:0]   new_r;
   logic [WIDTH-1:0] new_q;

   // Shift the next dividend bit into the partial remainder, then trial-subtract
   // by adding the inverted divisor with carry-in 1; the carry-out means no borrow.
   always_comb begin
      trial = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
      {no_borrow, diff} = {1'b0, trial} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
      new_r = no_borrow ? diff : trial;
      new_q = {q[WIDTH-2:0], no_borrow};
   end

   // Control and datapath share one register block; the last CALC step writes
   // its results straight into the outputs so Done and the results appear together.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         r         <= '0;
         q         <= '0;
         d         <= '0;
         count     <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Run) begin
                  if (Divisor == '0) begin
                     Quotient  <= '1;
                     Remainder <= Dividend;
                     DivByZero <= 1'b1;
                     Done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     d     <= Divisor;
                     q     <= Dividend;
                     r     <= '0;
                     count <= '0;
                     Busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               r     <= new_r;
               q     <= new_q;
               count <= count + CW'(1);
               if (count == LAST_STEP) begin
                  Quotient  <= new_q;
                  Remainder <= new_r[WIDTH-1:0];
                  DivByZero <= 1'b0;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // Hold here while the button is still pressed so one press gives one division.
               if (!Run) begin
                  Done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               Busy  <= 1'b0;
               Done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
